// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: owns refresh timing, snapshots digits per frame, PWM-dims per slot.
// Optional leading-zero blanking is compiled in when SEG_LZB_EN is defined.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 100000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digit_data,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic [3:0]                    brightness,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [6:0]                    cathode,
  output logic                          dp,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
  output logic                          frame_tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam int KW = $clog2(NUM_DIGITS);
  localparam int TW = CW + 5;

  localparam logic [CW-1:0]         CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [KW-1:0]         SLOT_LAST = KW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0]            SEG_OFF   = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF    = ACTIVE_LOW;

  // Standard hex decode, active-high, bit0 = a ... bit6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [KW-1:0]           k_q, k_d;
  logic [4*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0]   dp_snap_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [3:0]              bright_q;

  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              cathode_q, cathode_d;
  logic                    dp_q, dp_d;
  logic [KW-1:0]           sel_q;
  logic                    tick_q, tick_d;

  logic                    slot_start, frame_start;
  logic [4*NUM_DIGITS-1:0] data_eff;
  logic [NUM_DIGITS-1:0]   dp_eff, blank_eff, lzb_mask, dark;
  logic [3:0]              bright_eff, nib;
  logic [TW-1:0]           thr_full, thr;
  logic [KW-1:0]           sel;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   one_hot;

  // On the snapshot / latch cycle the live inputs are used directly, so the
  // fresh frame and fresh brightness are visible from the very first slot cycle.
  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_start  = (cnt_q == '0);
    frame_start = slot_start && (k_q == '0);
    data_eff    = frame_start ? digit_data : data_q;
    dp_eff      = frame_start ? dp_in      : dp_snap_q;
    blank_eff   = frame_start ? blank_mask : blank_q;
    bright_eff  = slot_start  ? brightness : bright_q;

    thr_full = (TW'(bright_eff) + TW'(1)) * TW'(PRESCALE);
    thr      = thr_full >> 4;

    lzb_mask = '0;
`ifdef SEG_LZB_EN
    begin
      logic seen;
      seen = 1'b0;
      for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
        if (!seen && data_eff[4*j +: 4] == 4'h0) lzb_mask[j] = 1'b1;
        else                                     seen        = 1'b1;
      end
    end
`endif
    dark = blank_eff | lzb_mask;

    sel = SLOT_LAST - k_q;
    nib = data_eff[4*int'(sel) +: 4];
    lit = (TW'(cnt_q) < thr) && !dark[sel];

    one_hot   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << sel;
    anode_d   = (lit ? one_hot : '0) ^ {NUM_DIGITS{ACTIVE_LOW}};
    cathode_d = (lit ? hex_to_seg(nib) : 7'h00) ^ {7{ACTIVE_LOW}};
    dp_d      = (lit && dp_eff[sel]) ^ ACTIVE_LOW;
    tick_d    = (k_q == SLOT_LAST) && (cnt_q == CNT_LAST);

    cnt_d = cnt_q + CW'(1);
    k_d   = k_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      k_d   = (k_q == SLOT_LAST) ? '0 : k_q + KW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  // NOTE: the snapshot registers are reset too (to all-blank), so a stale frame can never reach the pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      k_q       <= '0;
      data_q    <= '0;
      dp_snap_q <= '0;
      blank_q   <= '1;
      bright_q  <= '0;
      anode_q   <= AN_OFF;
      cathode_q <= SEG_OFF;
      dp_q      <= DP_OFF;
      sel_q     <= '0;
      tick_q    <= 1'b0;
    end else if (!enable) begin
      cnt_q     <= '0;
      k_q       <= '0;
      anode_q   <= AN_OFF;
      cathode_q <= SEG_OFF;
      dp_q      <= DP_OFF;
      sel_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      k_q   <= k_d;
      if (frame_start) begin
        data_q    <= digit_data;
        dp_snap_q <= dp_in;
        blank_q   <= blank_mask;
      end
      if (slot_start) bright_q <= brightness;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
      dp_q      <= dp_d;
      sel_q     <= sel;
      tick_q    <= tick_d;
    end
  end

  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign dp         = dp_q;
  assign digit_sel  = sel_q;
  assign frame_tick = tick_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed seven-segment display scanner; the next-generation replacement for fixed 4-digit anode selection driven by an external refresh count. The block owns its refresh timing and scans `NUM_DIGITS` digits. It snapshots hex data once per frame, decodes it to segments, and drives anode, cathode and decimal point. It adds per-digit blanking and 16-level PWM brightness. It sits between the datapath's display registers and the board's seven-segment pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned; ≥2.
- `PRESCALE`, 100000: clock cycles per digit slot; ≥16.
- `ACTIVE_LOW`, 1: 1 means `anode`, `cathode` and `dp` are active-low; 0 means active-high.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous active-low reset.
- `enable`  in  1  scan enable.
- `digit_data`  in  4*NUM_DIGITS  hex nibble per digit; nibble j drives anode j.
- `dp_in`  in  NUM_DIGITS  decimal point per digit (1 = lit).
- `blank_mask`  in  NUM_DIGITS  1 = digit j is dark.
- `brightness`  in  4  0 = dimmest, 15 = full.
- `anode`  out  NUM_DIGITS  digit enables.
- `cathode`  out  7  segments; bit0 = a … bit6 = g.
- `dp`  out  1  decimal-point segment.
- `digit_sel`  out  clog2(NUM_DIGITS)  index of the anode currently addressed.
- `frame_tick`  out  1  one-cycle pulse at the end of each frame.

## Operation
- States:
  - IDLE (`enable`=0): counters held at slot 0, count 0; all outputs at their off level.
  - SCAN (`enable`=1).
  - IDLE→SCAN on `enable`=1. SCAN→IDLE on `enable`=0, immediately, with no frame completion.
- Prescale counter `cnt` runs 0..PRESCALE-1. On wrap, slot counter `k` advances 0..NUM_DIGITS-1 and then wraps to 0.
- Slot k addresses anode j = NUM_DIGITS-1-k, so scanning runs leftmost first.
- Snapshot:
  - Taken at every (k=0, cnt=0), including the first SCAN cycle.
  - Covers `digit_data`, `dp_in` and `blank_mask`.
  - Input changes mid-frame are invisible until the next frame.
- `brightness` is latched at every cnt=0, i.e. per slot.
- PWM threshold: thr = ((brightness+1)*PRESCALE)>>4, computed at full width (clog2(PRESCALE)+5 bits) with no truncation before the shift.
- Anode j is active iff SCAN, cnt < thr, and the snapshot `blank_mask[j]`=0. Otherwise all anodes are off.
- `cathode` carries the standard hex 0–F decode of snapshot nibble j. `dp` follows snapshot `dp_in[j]`. Both are forced off whenever anode j is off.
- Polarity: all "on/off" levels are mapped through `ACTIVE_LOW`.
- Simultaneous events: a snapshot and a brightness latch at the same cnt=0 both take effect. Reset dominates `enable`.

## Timing
- All outputs are registered: one cycle of latency from the (k, cnt) state to the pins.
- Reset values (apply on the cycle after `rst_n` is sampled low):
  - `anode` all off (all 1s when ACTIVE_LOW=1).
  - `cathode` off (7'h7F when ACTIVE_LOW=1).
  - `dp` off.
  - `digit_sel` = 0.
  - `frame_tick` = 0.
  - Counters zeroed; snapshot cleared to all-blank.
- `frame_tick` is high for exactly the one cycle after (k=NUM_DIGITS-1, cnt=PRESCALE-1). Period is NUM_DIGITS*PRESCALE cycles.
- `digit_sel` = NUM_DIGITS-1-k, registered.
- Reset asserted mid-frame: outputs go to reset values on the next edge. Scanning restarts at slot 0 with a fresh snapshot once `rst_n`=1 and `enable`=1.

## Configuration
- `SEG_LZB_EN` defined: leading-zero blanking.
  - Evaluated on the snapshot.
  - Digits are blanked from the most-significant (j=NUM_DIGITS-1) downward while their nibble is 0 and no nonzero nibble has been seen above them.
  - Digit 0 is never blanked by this rule.
  - Combined with `blank_mask` by OR.
  - `dp_in` of a LZB-blanked digit is also suppressed.
- Undefined: no leading-zero logic; only `blank_mask` blanks.

## Test plan
All tests use NUM_DIGITS=4, PRESCALE=16, ACTIVE_LOW=1.
- Reset: hold `rst_n`=0 with `enable`=1 → `anode`=4'b1111, `cathode`=7'h7F, `dp`=1, `digit_sel`=0, `frame_tick`=0.
- Full scan: `digit_data`=16'h1234, `brightness`=15, `enable`=1 →
  - `anode` cycles 0111, 1011, 1101, 1110, 16 cycles each.
  - Cathode sequence 7'h79, 7'h24, 7'h30, 7'h19.
  - `frame_tick` pulses every 64 cycles.
- Dimming: `brightness`=3 (thr=4) → each anode active for 4 of its 16 cycles; cathode off for the other 12. Switching to 15 mid-slot takes effect at the next slot.
- Snapshot: change `digit_data` from 16'h1234 to 16'hABCD during slot 1 → remainder of the frame still shows 2, 3, 4; the next frame shows A, B, C, D.
- Blank and dp: `blank_mask`=4'b0100, `dp_in`=4'b0001 → anode 2 never active; `dp`=0 only during the active cycles of anode 0.
- LZB, built with `SEG_LZB_EN`:
  - 16'h0050 → anodes 3 and 2 dark; digit 1 shows 5, digit 0 shows 0.
  - 16'h0000 → only digit 0 lit, showing 0.
  - Without the macro, all four digits are lit.
